uart_mmio: RTL and testbench

Memory-mapped UART peripheral on the CPU's data-memory bus, downstream of the load/store path. It decodes the UART address window, holds one TX byte and one RX byte, and serialises/deserialises 8N1 frames on the `UART_TX`/`UART_RX` pins. It raises `irq` so the control unit can vector to the exception handler.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_mmio_if.sv | 11 +
 rtl/uart_rx_core.sv | 116 +++++++++++
 rtl/uart_mmio.sv | 190 +++++++++++++++++++
 tb/tb_uart_mmio.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, CON bit indices, FSM state type and baud divider helper
// for the memory-mapped UART.
package uart_pkg;

   localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
   localparam logic [31:0] ADDR_CON = 32'h4000_0020;

   localparam int unsigned CON_TX_IE  = 0;
   localparam int unsigned CON_RX_IE  = 1;
   localparam int unsigned CON_RX_VLD = 2;
   localparam int unsigned CON_TX_DN  = 3;
   localparam int unsigned CON_TX_BSY = 4;
   localparam int unsigned CON_OVR    = 5;
   localparam int unsigned CON_FERR   = 6;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

   // Oversample tick fires every calc_div()+1 clock cycles.
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned baud,
                                            input int unsigned ovs);
      return clk_hz / (baud * ovs) - 1;
   endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Data-memory bus port of the UART: strobes, address, store and load data.
interface uart_mmio_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd_en, output wr_en, output addr, output wdata, input rdata);
   modport slave  (input rd_en, input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, oversampled mid-bit sampling, and
// single-cycle byte-valid / frame-error pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned DIV = 650,
   parameter int unsigned OVS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       ferr_o
);

   localparam logic [15:0] DIV_L    = 16'(DIV);
   localparam logic [7:0]  OVS_LAST = 8'(OVS - 1);
   localparam logic [7:0]  OVS_MID  = 8'(OVS / 2 - 1);

   uart_state_e state_q, state_d;
   logic        s1_q, s2_q, prev_q;
   logic [15:0] div_q, div_d;
   logic [7:0]  os_q, os_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        tick;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         prev_q  <= 1'b1;
         div_q   <= '0;
         os_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= rx_i;
         s2_q    <= s1_q;
         prev_q  <= s2_q;
         div_q   <= div_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      os_d    = os_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      tick    = (div_q == DIV_L);
      if (state_q != ST_IDLE) begin
         div_d = tick ? '0 : div_q + 16'd1;
         if (tick) os_d = (os_q == OVS_LAST) ? '0 : os_q + 8'd1;
      end
      case (state_q)
         ST_IDLE: begin
            if (prev_q && !s2_q) begin
               state_d = ST_START;
               div_d   = '0;
               os_d    = '0;
            end
         end
         ST_START: begin
            // Realign the tick phase to mid start bit so later samples land mid-bit.
            if (tick && os_q == OVS_MID) begin
               os_d    = '0;
               bit_d   = '0;
               state_d = s2_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick && os_q == OVS_LAST) begin
               shift_d = {s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick && os_q == OVS_LAST) begin
               if (s2_q) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign byte_o  = byte_q;
   assign valid_o = valid_q;
   assign ferr_o  = ferr_q;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: address decode, TXD/RXD/CON registers, 8N1 transmitter
// and interrupt generation; reception is delegated to uart_rx_core.
module uart_mmio
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned OVS    = 16
) (
   input  logic       sys_clk,
   input  logic       reset,
   uart_mmio_if.slave bus,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       irq
);

   localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD, OVS);
   localparam logic [15:0] DIV_L    = 16'(DIV);
   localparam logic [7:0]  OVS_LAST = 8'(OVS - 1);

   uart_state_e tx_state_q, tx_state_d;
   logic [15:0] tx_div_q, tx_div_d;
   logic [7:0]  tx_os_q, tx_os_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_line_q, tx_line_d;
   logic        tx_fin_q, tx_fin_d;
   logic        tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d;
   logic        rx_valid_q, rx_valid_d, tx_done_q, tx_done_d, tx_busy_q, tx_busy_d;
   logic        ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic [7:0]  core_byte;
   logic        core_valid, core_ferr;
   logic        con_rd, rxd_rd, txd_wr, con_wr, bit_end;
   logic [31:0] con_word;

   uart_rx_core #(.DIV(DIV), .OVS(OVS)) u_rx (
      .clk     (sys_clk),
      .reset   (reset),
      .rx_i    (uart_rx),
      .byte_o  (core_byte),
      .valid_o (core_valid),
      .ferr_o  (core_ferr)
   );

   assign con_rd = bus.rd_en && (bus.addr == ADDR_CON);
   assign rxd_rd = bus.rd_en && (bus.addr == ADDR_RXD);
   assign txd_wr = bus.wr_en && (bus.addr == ADDR_TXD);
   assign con_wr = bus.wr_en && (bus.addr == ADDR_CON);

   always_ff @(posedge sys_clk) begin
      if (!reset) begin
         tx_state_q <= ST_IDLE;
         tx_div_q   <= '0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
         tx_fin_q   <= 1'b0;
         tx_ie_q    <= 1'b0;
         rx_ie_q    <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_done_q  <= 1'b0;
         tx_busy_q  <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         irq_q      <= 1'b0;
         rx_byte_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_os_q    <= tx_os_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
         tx_fin_q   <= tx_fin_d;
         tx_ie_q    <= tx_ie_d;
         rx_ie_q    <= rx_ie_d;
         rx_valid_q <= rx_valid_d;
         tx_done_q  <= tx_done_d;
         tx_busy_q  <= tx_busy_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         irq_q      <= irq_d;
         rx_byte_q  <= rx_byte_d;
      end
   end

   // The line register lags the FSM by one cycle; tx_fin_q delays the
   // busy/done update by the same cycle so flags line up with the pin.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_os_d    = tx_os_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_fin_d   = 1'b0;
      bit_end    = (tx_div_q == DIV_L) && (tx_os_q == OVS_LAST);
      if (tx_state_q != ST_IDLE) begin
         tx_div_d = (tx_div_q == DIV_L) ? '0 : tx_div_q + 16'd1;
         if (tx_div_q == DIV_L) tx_os_d = (tx_os_q == OVS_LAST) ? '0 : tx_os_q + 8'd1;
      end
      case (tx_state_q)
         ST_IDLE: begin
            if (txd_wr && !tx_busy_q) begin
               tx_state_d = ST_START;
               tx_shift_d = bus.wdata[7:0];
               tx_div_d   = '0;
               tx_os_d    = '0;
               tx_bit_d   = '0;
            end
         end
         ST_START: if (bit_end) tx_state_d = ST_DATA;
         ST_DATA: begin
            if (bit_end) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               tx_state_d = ST_IDLE;
               tx_fin_d   = 1'b1;
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
      case (tx_state_q)
         ST_START: tx_line_d = 1'b0;
         ST_DATA:  tx_line_d = tx_shift_q[0];
         default:  tx_line_d = 1'b1;
      endcase
   end

   // Clears from register reads are applied first so same-cycle sets win.
   always_comb begin
      tx_ie_d    = tx_ie_q;
      rx_ie_d    = rx_ie_q;
      rx_valid_d = rx_valid_q;
      tx_done_d  = tx_done_q;
      tx_busy_d  = tx_busy_q;
      ovr_d      = ovr_q;
      ferr_d     = ferr_q;
      rx_byte_d  = rx_byte_q;
      if (con_wr) begin
         tx_ie_d = bus.wdata[0];
         rx_ie_d = bus.wdata[1];
      end
      if (con_rd) begin
         tx_done_d = 1'b0;
         ovr_d     = 1'b0;
         ferr_d    = 1'b0;
      end
      if (rxd_rd) rx_valid_d = 1'b0;
      if (txd_wr && !tx_busy_q && tx_state_q == ST_IDLE) tx_busy_d = 1'b1;
      if (tx_fin_q) begin
         tx_busy_d = 1'b0;
         tx_done_d = 1'b1;
      end
      if (core_valid) begin
         if (rx_valid_q && !rxd_rd) ovr_d = 1'b1;
         rx_valid_d = 1'b1;
         rx_byte_d  = core_byte;
      end
      if (core_ferr) ferr_d = 1'b1;
      irq_d = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid_q);
   end

   always_comb begin
      con_word             = '0;
      con_word[CON_TX_IE]  = tx_ie_q;
      con_word[CON_RX_IE]  = rx_ie_q;
      con_word[CON_RX_VLD] = rx_valid_q;
      con_word[CON_TX_DN]  = tx_done_q;
      con_word[CON_TX_BSY] = tx_busy_q;
      con_word[CON_OVR]    = ovr_q;
      con_word[CON_FERR]   = ferr_q;
      bus.rdata            = '0;
      if (bus.rd_en) begin
         if (bus.addr == ADDR_CON)      bus.rdata = con_word;
         else if (bus.addr == ADDR_RXD) bus.rdata = {24'b0, rx_byte_q};
      end
   end

   assign uart_tx = tx_line_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio at 160 clocks per bit, with TX line and
// RX byte scoreboards.
module tb_uart_mmio;
   import uart_pkg::*;

   localparam int unsigned BITC = 160;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic tx, irq;
   int   total = 0;
   int   bad = 0;
   logic tx_exp[$];
   logic [7:0] rx_exp[$];

   uart_mmio_if bus ();

   uart_mmio #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16)) dut (
      .sys_clk (clk),
      .reset   (rst_n),
      .bus     (bus),
      .uart_rx (rx),
      .uart_tx (tx),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      #1 d = bus.rdata;
      bus.rd_en = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      #1 d = bus.rdata;
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.wr_en = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_exp.push_back(1'b0);
      for (int i = 0; i < 8; i++) tx_exp.push_back(b[i]);
      tx_exp.push_back(1'b1);
   endtask

   task automatic watch_tx(input bit do_peek);
      logic e;
      logic [31:0] d;
      for (int b = 0; b < 10; b++) begin
         e = 1'b1;
         if (tx_exp.size() > 0) e = tx_exp.pop_front();
         else chk("tx_sb_empty", 32'd0, 32'd1);
         for (int c = 0; c < int'(BITC); c++) begin
            tick();
            chk("tx_line", {31'b0, tx}, {31'b0, e});
            if (do_peek) begin
               peek(ADDR_CON, d);
               chk("tx_busy", {31'b0, d[CON_TX_BSY]}, 32'd1);
            end
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BITC) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BITC) tick();
      end
      rx = stop;
      repeat (BITC) tick();
      rx = 1'b1;
      repeat (20) tick();
   endtask

   task automatic wait_rx_valid();
      logic [31:0] d;
      int n = 0;
      peek(ADDR_CON, d);
      while (!d[CON_RX_VLD] && n < 400) begin
         tick();
         peek(ADDR_CON, d);
         n++;
      end
      chk("rx_valid_seen", {31'b0, d[CON_RX_VLD]}, 32'd1);
   endtask

   task automatic rx_read_check();
      logic [31:0] d;
      logic [7:0] e;
      e = 8'h00;
      if (rx_exp.size() > 0) e = rx_exp.pop_front();
      else chk("rx_sb_empty", 32'd0, 32'd1);
      bus_read(ADDR_RXD, d);
      chk("rxd", d, {24'b0, e});
   endtask

   initial begin
      logic [31:0] d;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;

      // reset state
      repeat (3) tick();
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      peek(ADDR_CON, d);  chk("rst_con", d, 32'd0);
      peek(ADDR_RXD, d);  chk("rst_rxd", d, 32'd0);
      rst_n = 1'b1;
      tick();

      bus_write(32'h4000_0024, 32'h3);
      peek(ADDR_CON, d);  chk("unmapped_wr", d, 32'd0);
      peek(32'h4000_0010, d); chk("unmapped_rd", d, 32'd0);

      // TX 0xA5 with tx_irq_en
      bus_write(ADDR_CON, 32'h1);
      peek(ADDR_CON, d);  chk("con_wr", d, 32'h1);
      push_tx(8'hA5);
      bus_write(ADDR_TXD, 32'hFFFF_FFA5);
      chk("tx_lat", {31'b0, tx}, 32'd1);
      watch_tx(1'b1);
      chk("irq_pre", {31'b0, irq}, 32'd0);
      tick();
      peek(ADDR_CON, d);  chk("tx_done_con", d, 32'h09);
      chk("irq_lag", {31'b0, irq}, 32'd0);
      tick();
      chk("irq_tx", {31'b0, irq}, 32'd1);
      bus_read(ADDR_CON, d); chk("con_rd_tx", d, 32'h09);
      peek(ADDR_CON, d);  chk("con_clr_tx", d, 32'h01);
      tick();
      chk("irq_tx_clr", {31'b0, irq}, 32'd0);

      // write while busy is ignored
      push_tx(8'h11);
      bus_write(ADDR_TXD, 32'h11);
      fork
         watch_tx(1'b0);
         begin
            repeat (500) tick();
            bus_write(ADDR_TXD, 32'h22);
         end
      join
      for (int c = 0; c < 1700; c++) begin
         tick();
         chk("tx_no_second", {31'b0, tx}, 32'd1);
      end
      bus_read(ADDR_CON, d); chk("con_busy_wr", d, 32'h09);

      // RX 0x3C with rx_irq_en
      bus_write(ADDR_CON, 32'h2);
      rx_exp.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_rx_valid();
      peek(ADDR_CON, d);  chk("rx_con", d, 32'h06);
      chk("irq_rx", {31'b0, irq}, 32'd1);
      rx_read_check();
      peek(ADDR_CON, d);  chk("rx_vld_clr", d, 32'h02);
      chk("irq_rx_lag", {31'b0, irq}, 32'd1);
      tick();
      chk("irq_rx_clr", {31'b0, irq}, 32'd0);

      // overrun: the second byte overwrites the first
      rx_exp.push_back(8'h01);
      send_frame(8'h01, 1'b1);
      rx_exp.push_back(8'h02);
      send_frame(8'h02, 1'b1);
      wait_rx_valid();
      peek(ADDR_CON, d);  chk("ovr_con", d, 32'h26);
      void'(rx_exp.pop_front());
      rx_read_check();
      bus_read(ADDR_CON, d); chk("ovr_rd", d, 32'h22);
      peek(ADDR_CON, d);  chk("ovr_clr", d, 32'h02);

      // frame error with rx_valid clear
      send_frame(8'h55, 1'b0);
      repeat (5) tick();
      peek(ADDR_CON, d);  chk("ferr_con", d, 32'h42);
      bus_read(ADDR_CON, d); chk("ferr_rd", d, 32'h42);
      peek(ADDR_CON, d);  chk("ferr_clr", d, 32'h02);

      // frame error with rx_valid set keeps the old byte
      rx_exp.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_rx_valid();
      send_frame(8'hC3, 1'b0);
      repeat (5) tick();
      peek(ADDR_CON, d);  chk("ferr_vld_con", d, 32'h46);
      rx_read_check();
      bus_read(ADDR_CON, d);
      peek(ADDR_CON, d);  chk("ferr_vld_clr", d, 32'h02);

      // 40-cycle glitch sets nothing, receiver still works afterwards
      rx = 1'b0;
      repeat (40) tick();
      rx = 1'b1;
      repeat (400) tick();
      peek(ADDR_CON, d);  chk("glitch_con", d, 32'h02);
      rx_exp.push_back(8'hC3);
      send_frame(8'hC3, 1'b1);
      wait_rx_valid();
      rx_read_check();

      // reset mid-frame
      bus_write(ADDR_CON, 32'h1);
      bus_write(ADDR_TXD, 32'h77);
      repeat (699) tick();
      chk("pre_rst_line", {31'b0, tx}, 32'd0);
      rst_n = 1'b0;
      tick();
      chk("rst_mid_tx", {31'b0, tx}, 32'd1);
      peek(ADDR_CON, d);  chk("rst_mid_con", d, 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 1700; c++) begin
         tick();
         chk("rst_mid_idle", {31'b0, tx}, 32'd1);
      end
      peek(ADDR_CON, d);  chk("rst_mid_nodone", d, 32'd0);
      chk("rst_mid_irq", {31'b0, irq}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
